// File: rtl/i2s_tx_master_if.sv
// ----------------------------------------------------------------------------
// i2s_tx_master_if
//   Bundles the sample handshake and serial outputs of the I2S transmitter.
//   Parameter W : sample width in bits per channel.
//   Signals:
//     en           transmit enable (sampled at frame boundaries)
//     in_valid     sample pair offered by the source
//     in_left      left sample, two's complement
//     in_right     right sample, two's complement
//     in_ready     transmitter can take a pair (pending buffer empty)
//     ws           word select, 0 = left, 1 = right
//     sd           serial data, MSB first
//     frame_strobe pulse in the cycle driving the left MSB
//     underrun     pulse, with frame_strobe, when a frame started without data
//     underrun_cnt saturating underrun count
//   Modports:
//     master : transmitter side
//     slave  : sample source / serial sink side
// ----------------------------------------------------------------------------
interface i2s_tx_master_if #(
   parameter int unsigned W = 16
);
   logic         en;
   logic         in_valid;
   logic [W-1:0] in_left;
   logic [W-1:0] in_right;
   logic         in_ready;
   logic         ws;
   logic         sd;
   logic         frame_strobe;
   logic         underrun;
   logic [7:0]   underrun_cnt;

   modport master (
      input  en,
      input  in_valid,
      input  in_left,
      input  in_right,
      output in_ready,
      output ws,
      output sd,
      output frame_strobe,
      output underrun,
      output underrun_cnt
   );

   modport slave (
      output en,
      output in_valid,
      output in_left,
      output in_right,
      input  in_ready,
      input  ws,
      input  sd,
      input  frame_strobe,
      input  underrun,
      input  underrun_cnt
   );
endinterface

// File: rtl/i2s_tx_master.sv
// ----------------------------------------------------------------------------
// i2s_tx_master
//   I2S master transmitter for one stereo stream. Parallel left/right samples
//   arrive over a valid/ready handshake into a single pending buffer; at each
//   frame boundary the pending pair moves into the active frame register and
//   is shifted out MSB first, left then right, one bit per sck cycle. A frame
//   that starts with nothing pending is sent as silence and counted as an
//   underrun (count saturates at 255).
//
//   Parameter W : sample width per channel (4..32); a frame is 2*W cycles.
//   Ports:
//     sck  bit clock, all logic on its rising edge
//     rst  asynchronous reset, active low
//     bus  i2s_tx_master_if.master (handshake, ws/sd and status outputs)
//
//   Frame position c runs 0..2W-1. Cycle c=1 carries the left MSB and
//   c=0 carries the previous frame's right LSB, so ws always leads the MSB
//   by one cycle. Frames are only started or stopped at the c=0 boundary.
// ----------------------------------------------------------------------------
module i2s_tx_master #(
   parameter int unsigned W = 16
) (
   input  logic               sck,
   input  logic               rst,
   i2s_tx_master_if.master    bus
);

   localparam int unsigned FW = 2 * W;
   localparam int unsigned CW = $clog2(FW);
   localparam logic [CW-1:0] C_LAST = CW'(FW - 1);
   localparam logic [CW-1:0] C_MID  = CW'(W);

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   c_q, c_d;

   // pending buffer (one sample pair)
   logic [W-1:0]    pend_l_q, pend_l_d;
   logic [W-1:0]    pend_r_q, pend_r_d;
   logic            pend_full_q, pend_full_d;

   // active frame: bits still to be sent, next bit in the MSB position
   logic [FW-1:0]   shift_q, shift_d;

   // registered outputs
   logic            ws_q, ws_d;
   logic            sd_q, sd_d;
   logic            strobe_q, strobe_d;
   logic            ur_q, ur_d;
   logic [7:0]      cnt_q, cnt_d;

   logic            accept;
   logic            boundary;

   always_ff @(posedge sck or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         c_q         <= '0;
         pend_l_q    <= '0;
         pend_r_q    <= '0;
         pend_full_q <= 1'b0;
         shift_q     <= '0;
         ws_q        <= 1'b0;
         sd_q        <= 1'b0;
         strobe_q    <= 1'b0;
         ur_q        <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         c_q         <= c_d;
         pend_l_q    <= pend_l_d;
         pend_r_q    <= pend_r_d;
         pend_full_q <= pend_full_d;
         shift_q     <= shift_d;
         ws_q        <= ws_d;
         sd_q        <= sd_d;
         strobe_q    <= strobe_d;
         ur_q        <= ur_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      c_d         = c_q;
      pend_l_d    = pend_l_q;
      pend_r_d    = pend_r_q;
      pend_full_d = pend_full_q;
      shift_d     = {shift_q[FW-2:0], 1'b0};
      ws_d        = 1'b0;
      sd_d        = 1'b0;
      strobe_d    = 1'b0;
      ur_d        = 1'b0;
      cnt_d       = cnt_q;

      accept   = bus.in_valid && !pend_full_q;
      boundary = (state_q == S_IDLE) || (c_q == '0);

      // Accept only happens with the buffer empty, and a load only clears
      // it when full, so the two updates below never collide.
      if (accept) begin
         pend_l_d    = bus.in_left;
         pend_r_d    = bus.in_right;
         pend_full_d = 1'b1;
      end

      if (boundary) begin
         if (bus.en) begin
            state_d  = S_RUN;
            c_d      = CW'(1);
            strobe_d = 1'b1;
            ws_d     = 1'b0;
            if (pend_full_q) begin
               // left MSB goes straight to sd; the rest queues behind it
               sd_d        = pend_l_q[W-1];
               shift_d     = {pend_l_q[W-2:0], pend_r_q, 1'b0};
               pend_full_d = 1'b0;
            end else begin
               sd_d    = 1'b0;
               shift_d = '0;
               ur_d    = 1'b1;
               if (cnt_q != '1) begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end else begin
            state_d = S_IDLE;
            c_d     = '0;
            shift_d = shift_q;
         end
      end else begin
         c_d  = (c_q == C_LAST) ? '0 : c_q + CW'(1);
         ws_d = (c_d >= C_MID);
         sd_d = shift_q[FW-1];
      end
   end

   assign bus.in_ready     = !pend_full_q;
   assign bus.ws           = ws_q;
   assign bus.sd           = sd_q;
   assign bus.frame_strobe = strobe_q;
   assign bus.underrun     = ur_q;
   assign bus.underrun_cnt = cnt_q;

endmodule
